mem_access_sequencer: RTL

- Initiator side of the core's data-memory port: accepts load/store/fill/copy requests from the execute stage, drives the 2-bit op/addr/write_data interface of the memory manager, and captures read_data.
- Sits between execute and the memory manager. Load results return to writeback over a valid/ready stream.
- Memory side is one word per cycle. Reads are combinational, valid in the same cycle op=MEM_READ. Writes commit at the next posedge.

---
 rtl/mem_access_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// Data-memory initiator: sequences LOAD/STORE/FILL/COPY requests into single-word
// memory-manager accesses and returns load words over a valid/ready stream.
module mem_access_sequencer #(
  parameter int unsigned DATA_WORDS = 256,
  parameter int unsigned LEN_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [15:0]      req_addr,
  input  logic [15:0]      req_src,
  input  logic [LEN_W-1:0] req_len,
  input  logic [15:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_last,
  output logic [1:0]       mem_op,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned DW = 16;
  localparam int unsigned EW = DW + 1;
  localparam logic [EW-1:0] LIMIT = EW'(DATA_WORDS);

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  localparam logic [1:0] KIND_LOAD  = 2'd0;
  localparam logic [1:0] KIND_STORE = 2'd1;
  localparam logic [1:0] KIND_FILL  = 2'd2;
  localparam logic [1:0] KIND_COPY  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, ACCEPT, RD, WAIT_RSP, WR, CP_RD, CP_WR, DONE
  } state_t;

  state_t            state;
  logic [1:0]        kind_q;
  logic [DW-1:0]     addr_q;
  logic [DW-1:0]     src_q;
  logic [LEN_W-1:0]  len_q;
  logic [DW-1:0]     wdata_q;
  logic [LEN_W-1:0]  idx;
  logic [DW-1:0]     temp_q;
  logic              err_q;

  logic [EW-1:0]     dst_end;
  logic [EW-1:0]     src_end;
  logic              last_word;
  logic              rsp_free;

  // End addresses are formed in 17 bits so a base near 0xFFFF cannot wrap into range.
  assign dst_end   = {1'b0, addr_q} + EW'(len_q) - EW'(1);
  assign src_end   = {1'b0, src_q}  + EW'(len_q) - EW'(1);
  assign last_word = (idx == len_q - LEN_W'(1));
  assign rsp_free  = !rsp_valid || rsp_ready;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign err       = (state == DONE) && err_q;

  // Memory-side drive; a read in RD only goes out when the response slot frees this cycle.
  always_comb begin
    mem_op    = MEM_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      RD: begin
        if (rsp_free) begin
          mem_op   = MEM_READ;
          mem_addr = addr_q + DW'(idx);
        end
      end
      WR: begin
        mem_op    = MEM_WRITE;
        mem_addr  = addr_q + DW'(idx);
        mem_wdata = wdata_q;
      end
      CP_RD: begin
        mem_op   = MEM_READ;
        mem_addr = src_q + DW'(idx);
      end
      CP_WR: begin
        mem_op    = MEM_WRITE;
        mem_addr  = addr_q + DW'(idx);
        mem_wdata = temp_q;
      end
      default: ;
    endcase
    // The memory manager does not see reset, so no access may escape during it.
    if (reset) mem_op = MEM_NONE;
  end

  // Sequencer state, request latches and response register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      kind_q    <= '0;
      addr_q    <= '0;
      src_q     <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      idx       <= '0;
      temp_q    <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            kind_q  <= req_kind;
            addr_q  <= req_addr;
            src_q   <= req_src;
            len_q   <= req_len;
            wdata_q <= req_wdata;
            state   <= ACCEPT;
          end
        end
        ACCEPT: begin
          idx   <= '0;
          err_q <= 1'b0;
          if (len_q == '0) begin
            state <= DONE;
          end else if ((dst_end >= LIMIT) ||
                       ((kind_q == KIND_COPY) && (src_end >= LIMIT))) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            case (kind_q)
              KIND_LOAD:  state <= RD;
              KIND_STORE: state <= WR;
              KIND_FILL:  state <= WR;
              default:    state <= CP_RD;
            endcase
          end
        end
        RD: begin
          if (rsp_free) begin
            rsp_data  <= mem_rdata;
            rsp_valid <= 1'b1;
            rsp_last  <= last_word;
            idx       <= idx + LEN_W'(1);
            if (last_word) state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            state     <= DONE;
          end
        end
        WR: begin
          idx <= idx + LEN_W'(1);
          if (last_word) state <= DONE;
        end
        CP_RD: begin
          temp_q <= mem_rdata;
          state  <= CP_WR;
        end
        CP_WR: begin
          idx   <= idx + LEN_W'(1);
          state <= last_word ? DONE : CP_RD;
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
